uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that pairs with the team's UART receiver on the same link. It accepts bytes over a valid/ready handshake into a small FIFO and serializes each as one 8N1 frame on `tx_out`: start bit (0), 8 data bits LSB first, stop bit (1). With the default `CLKS_PER_BIT = 1`, frames match the receiver's one-bit-per-clock sampling directly, and consecutive bytes go out back-to-back.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..65535.
- `FIFO_DEPTH`, default 4: byte FIFO entries; must be a power of two, at least 2.
- Reset is `rst`: asynchronous, active-high. The clock is `clk`.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous active-high reset.
- `tx_data`  in  8: byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1: producer offers `tx_data`.
- `tx_ready`  out  1: FIFO not full; combinational from FIFO count.
- `tx_out`  out  1: serial line, registered, idles high.
- `busy`  out  1: a frame is in progress or the FIFO is non-empty.

## Operation
- Reset values:
  - `tx_out` = 1, `busy` = 0, `tx_ready` = 1.
  - FIFO empty; FSM in IDLE; bit index and baud counter = 0.
- Handshake:
  - A byte is accepted on any edge with `tx_valid && tx_ready`.
  - `tx_valid` high while `tx_ready` = 0 is held off, not dropped; the producer keeps data stable.
- FSM states:
  - **IDLE**: `tx_out` = 1. If the FIFO is non-empty: pop the head into the shift register, drive `tx_out` = 0, go to START.
  - **START**: hold 0 for `CLKS_PER_BIT` cycles. Then drive `shift[0]`, clear the bit index, go to DATA.
  - **DATA**: hold each bit for `CLKS_PER_BIT` cycles, then shift right. After bit index 7, drive 1 and go to STOP.
  - **STOP**: hold 1 for `CLKS_PER_BIT` cycles. Then, if the FIFO is non-empty, pop and drive 0 (START) with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT+1)`, minimum 1.
  - Reloads to `CLKS_PER_BIT-1` on every bit boundary; the bit ends when the count reaches 0.
  - With `CLKS_PER_BIT = 1` every cycle is a boundary.
- FIFO:
  - Push and pop on the same cycle are both honoured; the count is unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped on the following edge at the earliest.
- `busy` = (state != IDLE) || (count != 0). It is registered-equivalent and glitch-free at cycle level.

## Timing
- Latency: byte accepted at edge k into an empty FIFO while IDLE.
  - `tx_out` falls at edge k+1.
  - The frame occupies exactly `10*CLKS_PER_BIT` cycles.
  - `tx_out` returns high at edge k+1+`9*CLKS_PER_BIT`.
- Back-to-back throughput: one frame per `10*CLKS_PER_BIT` cycles.
- `tx_ready`:
  - Drops in the cycle after the push that makes the FIFO full.
  - Rises in the cycle after the pop that frees an entry.
- Mid-frame reset: `tx_out` is forced to 1 immediately (asynchronous). The partial frame is abandoned, the FIFO is flushed, and the next frame starts from IDLE.
- Mid-frame `tx_data` and `tx_valid` activity never alters the frame in flight.

## Structure
- Shared package `uart_pkg` holds:
  - `DATA_BITS` = 8.
  - `LINE_IDLE` = 1'b1, `START_BIT` = 1'b0.
  - The state enum `uart_tx_state_t` {IDLE, START, DATA, STOP}.
  - The receiver shares these constants.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO with parameter `DEPTH`.
  - Ports: push/pop/din/dout/count/full/empty.
  - Pointers one bit wider than the address to distinguish full from empty.
- Top level contains the FSM, baud counter, bit index and shift register.

## Test plan
- Single byte, `CLKS_PER_BIT` = 1, send 0xA5:
  - `tx_out` sequence from edge k+1: 0,1,0,1,0,0,1,0,1,1, then idle 1.
  - `busy` falls after the stop bit.
- Loopback into the team receiver, bytes 0x00, 0xFF, 0x3C, 0x81 pushed back-to-back:
  - Receiver `ready` pulses 4 times, `rx_data` in order.
  - No idle cycles between frames.
- `CLKS_PER_BIT` = 16, byte 0x55: each line level holds exactly 16 cycles; total frame 160 cycles.
- `FIFO_DEPTH` = 4, hold `tx_valid` high with 6 bytes:
  - `tx_ready` falls after the 5th acceptance (1 in shifter + 4 queued).
  - All 6 bytes are transmitted in order with no loss or duplication.
- Reset asserted mid-DATA bit 3 with 2 bytes queued:
  - `tx_out` = 1 immediately, `busy` = 0, `tx_ready` = 1.
  - After release, the line stays high until a new push.
- Push while the FIFO holds 1 entry and STOP ends in the same cycle: both honoured, count unchanged, next frame starts without a gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;
    localparam logic        START_BIT = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry an extra wrap bit to separate full from empty.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake into a FIFO, serialized LSB first on tx_out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy
);

    localparam int unsigned BAUD_W = clog2_min1(CLKS_PER_BIT + 1);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT    = IDX_W'(DATA_BITS - 1);

    uart_tx_state_t       state;
    uart_tx_state_t       state_nxt;
    logic [7:0]           shift;
    logic [7:0]           shift_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_nxt;
    logic                 tx_nxt;
    logic                 pop;
    logic                 push;
    logic                 bit_end;
    logic [7:0]           fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign bit_end  = (baud_cnt == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx_out   <= LINE_IDLE;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            bit_idx  <= bit_idx_nxt;
            baud_cnt <= baud_nxt;
            tx_out   <= tx_nxt;
        end
    end

    // Next-state, next line level and FIFO pop; a new frame is loaded straight from STOP when data waits.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        baud_nxt    = baud_cnt;
        tx_nxt      = tx_out;
        pop         = 1'b0;

        if (state != IDLE) begin
            baud_nxt = bit_end ? BAUD_RELOAD : baud_cnt - BAUD_W'(1);
        end

        case (state)
            IDLE: begin
                tx_nxt = LINE_IDLE;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_dout;
                    tx_nxt    = START_BIT;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nxt      = shift[0];
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_nxt    = LINE_IDLE;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt   = shift >> 1;
                        tx_nxt      = shift[1];
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_dout;
                        tx_nxt    = START_BIT;
                        state_nxt = START;
                    end else begin
                        baud_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tx_nxt    = LINE_IDLE;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: serial monitors decode the line and compare against queued expectations.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic       tx1;
    logic       busy1;
    logic [7:0] tx_data16;
    logic       tx_valid16;
    logic       tx_ready16;
    logic       tx16;
    logic       busy16;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    logic [7:0] q1[$];
    int         q16[$];
    int         starts1[$];
    int unsigned n_frames1 = 0;

    uart_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx_out   (tx1),
        .busy     (busy1)
    );

    uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data16),
        .tx_valid (tx_valid16),
        .tx_ready (tx_ready16),
        .tx_out   (tx16),
        .busy     (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Line decoder for the CLKS_PER_BIT=1 instance: one bit per negedge sample.
    int         mpos = 0;
    logic [7:0] mbyte;
    int         fstart;
    always @(negedge clk) begin
        if (rst) begin
            mpos = 0;
        end else if (mpos == 0) begin
            if (tx1 === 1'b0) begin
                mpos   = 1;
                mbyte  = '0;
                fstart = int'(cyc);
            end
        end else if (mpos <= 8) begin
            mbyte[mpos-1] = tx1;
            mpos++;
        end else begin
            check("stop_bit", 32'(tx1), 32'd1);
            if (q1.size() == 0) fail_now("unexpected_frame");
            else check("rx_byte", 32'(mbyte), 32'(q1.pop_front()));
            starts1.push_back(fstart);
            n_frames1++;
            mpos = 0;
        end
    end

    // Run-length monitor for the CLKS_PER_BIT=16 instance.
    bit m16_started = 1'b0;
    logic m16_prev  = 1'b1;
    int m16_run     = 0;
    always @(negedge clk) begin
        if (rst) begin
            m16_started = 1'b0;
            m16_prev    = 1'b1;
            m16_run     = 0;
        end else if (tx16 !== m16_prev) begin
            if (m16_started) begin
                if (q16.size() == 0) fail_now("unexpected_run16");
                else check("run16", 32'(m16_run), 32'(q16.pop_front()));
            end
            m16_started = 1'b1;
            m16_run     = 1;
            m16_prev    = tx16;
        end else begin
            m16_run++;
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push1(input logic [7:0] b, input bit expect_it);
        int n = 0;
        tx_data1  = b;
        tx_valid1 = 1'b1;
        while (tx_ready1 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("push_timeout");
        if (expect_it) q1.push_back(b);
        @(negedge clk);
        tx_valid1 = 1'b0;
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (!(busy1 === 1'b0 && mpos == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_gaps(input int nfr);
        int sz = starts1.size();
        if (sz < nfr) begin
            fail_now("too_few_frames_for_gap_check");
        end else begin
            for (int i = sz - nfr + 1; i < sz; i++)
                check("frame_spacing", 32'(starts1[i] - starts1[i-1]), 32'd10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame_a5;
        int         lows;
        int         t0;
        int         n;
        frame_a5   = 10'b11_0100_1010;
        rst        = 1'b1;
        tx_data1   = '0;
        tx_valid1  = 1'b0;
        tx_data16  = '0;
        tx_valid16 = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx1", 32'(tx1), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_ready1", 32'(tx_ready1), 32'd1);
        check("rst_tx16", 32'(tx16), 32'd1);
        check("rst_busy16", 32'(busy16), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: exact line sequence and busy release.
        push1(8'hA5, 1'b1);
        check("a5_busy_after_push", 32'(busy1), 32'd1);
        check("a5_line_before_start", 32'(tx1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("a5_bit%0d", i), 32'(tx1), 32'(frame_a5[i]));
        end
        check("a5_busy_in_stop", 32'(busy1), 32'd1);
        @(negedge clk);
        check("a5_idle_line", 32'(tx1), 32'd1);
        check("a5_busy_fall", 32'(busy1), 32'd0);
        wait_idle1();

        // Back-to-back bytes with no idle gap.
        starts1.delete();
        push1(8'h00, 1'b1);
        push1(8'hFF, 1'b1);
        push1(8'h3C, 1'b1);
        push1(8'h81, 1'b1);
        wait_idle1();
        check("b2b_frames", 32'(starts1.size()), 32'd4);
        check_gaps(4);

        // FIFO fill with tx_valid held high.
        starts1.delete();
        push1(8'h11, 1'b1);
        push1(8'h22, 1'b1);
        push1(8'h33, 1'b1);
        push1(8'h44, 1'b1);
        check("ready_after_4", 32'(tx_ready1), 32'd1);
        push1(8'h55, 1'b1);
        check("ready_after_5", 32'(tx_ready1), 32'd0);
        push1(8'h66, 1'b1);
        wait_idle1();
        check("fill_frames", 32'(starts1.size()), 32'd6);
        check_gaps(6);

        // Push coinciding with STOP-end pop while one entry is queued.
        starts1.delete();
        push1(8'hC3, 1'b1);
        push1(8'h5A, 1'b1);
        repeat (9) @(negedge clk);
        check("coinc_count_before", 32'(dut1.u_fifo.count), 32'd1);
        push1(8'h96, 1'b1);
        check("coinc_count_after", 32'(dut1.u_fifo.count), 32'd1);
        check("coinc_start_bit", 32'(tx1), 32'd0);
        wait_idle1();
        check_gaps(3);

        // 16 clocks per bit, byte 0x55: nine alternating runs of 16, frame of 160.
        for (int i = 0; i < 9; i++) q16.push_back(16);
        tx_data16  = 8'h55;
        tx_valid16 = 1'b1;
        @(negedge clk);
        tx_valid16 = 1'b0;
        n = 0;
        while (tx16 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("cpb16_start_timeout");
        t0 = int'(cyc);
        n  = 0;
        while (busy16 !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("cpb16_busy_timeout");
        check("cpb16_frame_len", 32'(int'(cyc) - t0), 32'd160);
        check("cpb16_runs_left", 32'(q16.size()), 32'd0);
        check("cpb16_idle_line", 32'(tx16), 32'd1);

        // Reset during data bit 3 with two bytes queued; nothing is expected on the line.
        push1(8'hF0, 1'b0);
        push1(8'h0F, 1'b0);
        push1(8'hAA, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx1), 32'd1);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_ready", 32'(tx_ready1), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1) lows++;
        end
        check("postrst_line_low_cycles", 32'(lows), 32'd0);
        check("postrst_busy", 32'(busy1), 32'd0);

        // Fresh frame after reset starts from IDLE.
        push1(8'h3E, 1'b1);
        wait_idle1();

        check("scoreboard_left", 32'(q1.size()), 32'd0);
        check("total_frames", 32'(n_frames1), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
